// File: rtl/exponent_extractor.sv
// Computes the shared (maximum) exponent of each GROUP_SIZE-element group of a
// floating-point activation stream and writes one result per group to the exponent buffer.
module exponent_extractor #(
    parameter int DATA_WIDTH        = 8,
    parameter int MANT_WIDTH        = 7,
    parameter int GROUP_SIZE        = 16,
    parameter int BUFFER_ADDR_WIDTH = 15
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start_i,
    input  logic [BUFFER_ADDR_WIDTH-1:0]        base_addr_i,
    input  logic [BUFFER_ADDR_WIDTH-1:0]        num_groups_i,
    input  logic                                in_valid_i,
    output logic                                in_ready_o,
    input  logic [DATA_WIDTH+MANT_WIDTH:0]      in_data_i,
    output logic                                buffer_wr_en_o,
    output logic [BUFFER_ADDR_WIDTH-1:0]        buffer_wr_addr_o,
    output logic [DATA_WIDTH-1:0]               buffer_data_o,
    output logic                                busy_o,
    output logic                                done_o
);

    localparam int CNT_W = $clog2(GROUP_SIZE);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(GROUP_SIZE - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_LAST = 2'd2;

    logic [1:0]                   state_q, state_d;
    logic [BUFFER_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BUFFER_ADDR_WIDTH-1:0] grp_q, grp_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]        max_q, max_d;
    logic                         wr_en_q, wr_en_d;
    logic [BUFFER_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]        wr_data_q, wr_data_d;
    logic                         done_q, done_d;

    logic [DATA_WIDTH-1:0] exp_field;
    logic [DATA_WIDTH-1:0] new_max;
    logic                  handshake;
    logic                  unused_bits;

    // Sign and mantissa never influence the shared exponent.
    assign exp_field   = in_data_i[MANT_WIDTH +: DATA_WIDTH];
    assign unused_bits = ^{in_data_i[DATA_WIDTH+MANT_WIDTH], in_data_i[MANT_WIDTH-1:0]};

    assign in_ready_o = (state_q == ST_RUN);
    assign busy_o     = (state_q != ST_IDLE);
    assign handshake  = in_valid_i && in_ready_o;
    assign new_max    = (exp_field > max_q) ? exp_field : max_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        grp_d     = grp_q;
        cnt_d     = cnt_q;
        max_d     = max_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    addr_d  = base_addr_i;
                    grp_d   = num_groups_i;
                    cnt_d   = '0;
                    max_d   = '0;
                    state_d = (num_groups_i == '0) ? ST_LAST : ST_RUN;
                end
            end
            ST_RUN: begin
                if (handshake) begin
                    if (cnt_q == LAST_IDX) begin
                        // Clearing max here lets the next group's first element seed it cleanly.
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = new_max;
                        addr_d    = addr_q + 1'b1;
                        grp_d     = grp_q - 1'b1;
                        cnt_d     = '0;
                        max_d     = '0;
                        if (grp_q == BUFFER_ADDR_WIDTH'(1)) begin
                            state_d = ST_LAST;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        max_d = new_max;
                    end
                end
            end
            ST_LAST: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_d == ST_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            grp_q     <= '0;
            cnt_q     <= '0;
            max_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            grp_q     <= grp_d;
            cnt_q     <= cnt_d;
            max_q     <= max_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    assign buffer_wr_en_o   = wr_en_q;
    assign buffer_wr_addr_o = wr_addr_q;
    assign buffer_data_o    = wr_data_q;
    assign done_o           = done_q;

endmodule

// File: tb/tb_exponent_extractor.sv
// Bench for exponent_extractor: directed passes checked every cycle against a
// group-max reference model, plus literal expectations on the recorded writes.
module tb_exponent_extractor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [14:0] base_addr_i = '0;
    logic [14:0] num_groups_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [15:0] in_data_i = '0;
    logic        buffer_wr_en_o;
    logic [14:0] buffer_wr_addr_o;
    logic [7:0]  buffer_data_o;
    logic        busy_o;
    logic        done_o;

    exponent_extractor dut (
        .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
        .num_groups_i(num_groups_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_data_i(in_data_i), .buffer_wr_en_o(buffer_wr_en_o),
        .buffer_wr_addr_o(buffer_wr_addr_o), .buffer_data_o(buffer_data_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    bit en    = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct { int addr; int data; int c; } wr_t;
    wr_t log_q[$];
    int  done_cyc = -1;

    // Reference model: spec-level pass state (0 idle, 1 accepting, 2 finishing),
    // exponents of the open group, and the outputs expected in the current cycle.
    int m_phase = 0, m_base = 0, m_groups = 0, m_g = 0;
    int m_elems[$];
    int e_wr = 0, e_addr = 0, e_data = 0, e_done = 0;

    always @(negedge clk) begin
        int n_wr, n_addr, n_data, n_done, n_phase, mx;
        if (en) begin
            chk("wr_en", buffer_wr_en_o, e_wr);
            chk("wr_addr", buffer_wr_addr_o, e_addr);
            chk("wr_data", buffer_data_o, e_data);
            chk("done", done_o, e_done);
            chk("in_ready", in_ready_o, (m_phase == 1) ? 1 : 0);
            chk("busy", busy_o, (m_phase != 0) ? 1 : 0);
            if (buffer_wr_en_o) log_q.push_back('{int'(buffer_wr_addr_o), int'(buffer_data_o), cyc});
            if (done_o) done_cyc = cyc;
        end
        n_wr = 0; n_done = 0; n_addr = e_addr; n_data = e_data; n_phase = m_phase;
        if (rst) begin
            n_addr = 0; n_data = 0; n_phase = 0;
            m_elems.delete();
        end else begin
            case (m_phase)
                0: if (start_i) begin
                    m_base = int'(base_addr_i); m_groups = int'(num_groups_i); m_g = 0;
                    m_elems.delete();
                    if (m_groups == 0) begin n_phase = 2; n_done = 1; end
                    else n_phase = 1;
                end
                1: if (in_valid_i) begin
                    m_elems.push_back(int'(in_data_i[14:7]));
                    if (m_elems.size() == 16) begin
                        mx = 0;
                        foreach (m_elems[i]) if (m_elems[i] > mx) mx = m_elems[i];
                        n_wr = 1; n_data = mx; n_addr = (m_base + m_g) % 32768;
                        m_g++;
                        m_elems.delete();
                        if (m_g == m_groups) begin n_phase = 2; n_done = 1; end
                    end
                end
                default: n_phase = 0;
            endcase
        end
        e_wr = n_wr; e_addr = n_addr; e_data = n_data; e_done = n_done; m_phase = n_phase;
    end

    int stim[$];

    task automatic run_pass(input int base, input int ng, input int nelem, input bit stall,
                            input int glitch_at, input bit wait_done);
        int idx, tmo;
        bit hs, v, got;
        log_q.delete();
        done_cyc = -1;
        @(posedge clk); #1;
        start_i = 1'b1; base_addr_i = 15'(base); num_groups_i = 15'(ng);
        @(posedge clk); #1;
        start_i = 1'b0;
        idx = 0; tmo = 0;
        while (idx < nelem && tmo < 2000) begin
            v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid_i = v;
            if (v) in_data_i = {1'($urandom_range(0, 1)), 8'(stim[idx]), 7'($urandom_range(0, 127))};
            else   in_data_i = {1'b0, 8'hFE, 7'h55};
            if (idx == glitch_at) begin
                start_i = 1'b1; base_addr_i = 15'h1234; num_groups_i = 15'd7;
            end else start_i = 1'b0;
            @(negedge clk);
            hs = v && in_ready_o;
            @(posedge clk); #1;
            if (hs) idx++;
            tmo++;
        end
        in_valid_i = 1'b0; start_i = 1'b0;
        if (idx < nelem) chk("feed_timeout", idx, nelem);
        if (wait_done) begin
            got = 1'b0;
            for (int i = 0; i < 60 && !got; i++) begin
                @(negedge clk);
                if (done_o) got = 1'b1;
            end
            chk("done_seen", got, 1);
            @(posedge clk); #1;
        end
    endtask

    wr_t ref_q[$];

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        en = 1'b1;
        @(negedge clk);
        chk("reset_wr_en", buffer_wr_en_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_ready", in_ready_o, 0);

        // single group 0x70..0x7F
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(8'h70 + i);
        run_pass(16'h0010, 1, 16, 1'b0, -1, 1'b1);
        chk("t1_nwr", log_q.size(), 1);
        if (log_q.size() == 1) begin
            chk("t1_addr", log_q[0].addr, 16'h0010);
            chk("t1_data", log_q[0].data, 8'h7F);
            chk("t1_done_with_wr", done_cyc, log_q[0].c);
        end

        // three back-to-back groups: maxima 0x85, 0x01, 0xFF (first)
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back((i == 7) ? 8'h85 : 8'h10 + i);
        for (int i = 0; i < 16; i++) stim.push_back((i == 3) ? 8'h01 : 8'h00);
        for (int i = 0; i < 16; i++) stim.push_back((i == 0) ? 8'hFF : 8'h20 + i);
        run_pass(16'h0200, 3, 48, 1'b0, -1, 1'b1);
        chk("t2_nwr", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("t2_a0", log_q[0].addr, 16'h0200); chk("t2_d0", log_q[0].data, 8'h85);
            chk("t2_a1", log_q[1].addr, 16'h0201); chk("t2_d1", log_q[1].data, 8'h01);
            chk("t2_a2", log_q[2].addr, 16'h0202); chk("t2_d2", log_q[2].data, 8'hFF);
            chk("t2_gap01", log_q[1].c - log_q[0].c, 16);
            chk("t2_gap12", log_q[2].c - log_q[1].c, 16);
        end

        // two groups without stalls, then identical data with random stalls
        stim.delete();
        for (int i = 0; i < 32; i++) stim.push_back((i * 37 + 5) % 200);
        run_pass(16'h0300, 2, 32, 1'b0, -1, 1'b1);
        ref_q = log_q;
        run_pass(16'h0300, 2, 32, 1'b1, -1, 1'b1);
        chk("t3_nwr", log_q.size(), ref_q.size());
        if (log_q.size() == 2 && ref_q.size() == 2) begin
            for (int i = 0; i < 2; i++) begin
                chk("t3_addr", log_q[i].addr, ref_q[i].addr);
                chk("t3_data", log_q[i].data, ref_q[i].data);
            end
        end

        // address wrap
        stim.delete();
        for (int i = 0; i < 32; i++) stim.push_back(i);
        run_pass(16'h7FFF, 2, 32, 1'b0, -1, 1'b1);
        chk("t4_nwr", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t4_a0", log_q[0].addr, 16'h7FFF); chk("t4_d0", log_q[0].data, 8'h0F);
            chk("t4_a1", log_q[1].addr, 16'h0000); chk("t4_d1", log_q[1].data, 8'h1F);
        end

        // zero groups
        run_pass(16'h0100, 0, 0, 1'b0, -1, 1'b1);
        chk("t5_nwr", log_q.size(), 0);

        // reset after 9 of 16 elements, then a clean pass
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back((i == 2) ? 8'hF0 : 8'h05);
        run_pass(16'h0040, 1, 9, 1'b0, -1, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_wr_en", buffer_wr_en_o, 0);
        chk("t6_addr", buffer_wr_addr_o, 0);
        chk("t6_data", buffer_data_o, 0);
        chk("t6_busy", busy_o, 0);
        chk("t6_done", done_o, 0);
        chk("t6_nwr", log_q.size(), 0);
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back((i == 11) ? 8'h33 : 8'h02);
        run_pass(16'h0050, 1, 16, 1'b0, -1, 1'b1);
        chk("t6b_nwr", log_q.size(), 1);
        if (log_q.size() == 1) begin
            chk("t6b_addr", log_q[0].addr, 16'h0050);
            chk("t6b_data", log_q[0].data, 8'h33);
        end

        // start pulsed mid-pass is ignored
        stim.delete();
        for (int i = 0; i < 32; i++) stim.push_back((i < 16) ? 8'h40 + i : 8'h90 - i);
        run_pass(16'h0060, 2, 32, 1'b0, 5, 1'b1);
        chk("t7_nwr", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t7_a0", log_q[0].addr, 16'h0060); chk("t7_d0", log_q[0].data, 8'h4F);
            chk("t7_a1", log_q[1].addr, 16'h0061); chk("t7_d1", log_q[1].data, 8'h80);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
